trivium_stream: RTL
===================

# trivium_stream

Parametrised Trivium keystream generator, successor to the single-bit core. It computes W keystream bits per clock, runs a configurable warm-up, and presents output words on a valid/ready handshake so downstream logic can stall without losing or skipping bits. It sits between key/IV configuration logic and the XOR datapath of the stream-cipher top level.

## Interface
- W, 8: keystream bits per cycle. Legal range 1..64.
- INIT_ROUNDS, 1152: warm-up state updates before the first output. Must be a multiple of W.
- Either violation is an elaboration error.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle request to (re)load key/iv and start warm-up.
- key  in  80  key, sampled when load=1.
- iv  in  80  IV, sampled when load=1.
- busy  out  1  high during warm-up (INIT).
- out_valid  out  1  ks holds a valid word.
- out_ready  in  1  consumer accepts the word.
- ks  out  W  keystream word; ks[0] is the earliest bit.

## Operation
- State s1..s288 uses 1-indexed Trivium numbering.
- Load mapping:
  - s(i+1)=key[i] and s(94+i)=iv[i] for i=0..79.
  - s286, s287, s288 = 1.
  - All other bits = 0.
- One step, over the current s:
  - t1=s66^s93; t2=s162^s177; t3=s243^s288.
  - z=t1^t2^t3.
  - t1^=s91&s92^s171; t2^=s175&s176^s264; t3^=s286&s287^s69.
  - (s1..s93)<=(t3,s1..s92); (s94..s177)<=(t1,s94..s176); (s178..s288)<=(t2,s178..s287).
- W steps are unrolled combinationally. Step k uses the state after k steps. ks[k]=z of step k.
- Because W≤64<66, each z depends only on pre-word state bits. Unrolling is a pure composition.
- FSM states and transitions:
  - IDLE → INIT on load.
  - INIT: advance W steps every cycle, with no handshake. An 11-bit round counter counts up by W. On reaching INIT_ROUNDS → RUN.
  - RUN: advance W steps only on out_valid&out_ready. Otherwise hold s.
  - RUN persists indefinitely; there is no word limit.
- load in any state (IDLE, INIT, RUN):
  - Reloads s from key/iv.
  - Clears the counter and enters INIT.
  - Any pending word is discarded and is not counted as consumed, even if out_ready=1.
- Priority: rst > load > handshake advance.
- Outputs:
  - busy=(state==INIT).
  - out_valid=(state==RUN).
  - ks is a function of registered s only, never of out_ready. ks is forced to 0 when out_valid=0.
- Reset values: state=IDLE, s=0, counter=0, busy=0, out_valid=0, ks=0.

## Timing
- Edge E0 samples load=1. After E0: busy=1 and s holds the loaded value.
- INIT spans N=INIT_ROUNDS/W cycles. After edge E_N: busy=0 and out_valid=1.
  - Defaults (W=8): N=144.
  - W=1: N=1152. W=64: N=18.
- In RUN, a word transfers on each edge with out_valid&out_ready. The next word is valid the following cycle, giving a throughput of W bits/cycle with no bubbles.
- With out_ready=0, ks and s are held stable across any number of cycles.
- rst high at any edge: outputs are at reset values in the next cycle, regardless of load or out_ready.
- The bit stream is invariant to W and to the stall pattern: concatenated accepted words equal the W=1 stream.

## Test plan
- Reset: assert rst 3 cycles mid-RUN with out_ready=1 → next cycle busy=0, out_valid=0, ks=0. The block stays IDLE until load.
- Known answer, W=1, INIT_ROUNDS=1152, key=0, iv=0, out_ready=1 → out_valid rises exactly 1152 cycles after E0. The first 512 bits match the bit-accurate software model using the mapping above.
- Width equivalence: same key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC for W=8 and W=64 → 1024 accepted bits match W=1 bit-for-bit. out_valid rises after 144 and 18 cycles respectively.
- Backpressure: W=8, random out_ready with 10 consecutive cycles low → ks is constant while low, no word is duplicated or skipped, and the stream equals the unstalled run.
- Reload mid-INIT: load again at cycle 50 of warm-up with a new iv → busy stays 1, out_valid rises N cycles after the second load, and the stream matches the model for the second key/iv.
- Reload in RUN with out_ready=1 on the same cycle → that word is not consumed, out_valid=0 next cycle, and busy=1 for N cycles.

Source files
------------

// File: rtl/trivium_stream.sv
// trivium_stream: W-bit-per-cycle Trivium keystream generator with a
// configurable warm-up and a valid/ready output handshake. State bit s(i)
// in Trivium's 1-indexed numbering is held at s_q[i-1].
module trivium_stream #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] ks
);

  // Reject illegal configurations at elaboration time.
  if (W < 1 || W > 64) begin : g_bad_w
    $error("trivium_stream: W=%0d outside 1..64", W);
  end
  if ((W >= 1) && ((INIT_ROUNDS % W) != 0 || INIT_ROUNDS < W || INIT_ROUNDS > 2047)) begin : g_bad_rounds
    $error("trivium_stream: INIT_ROUNDS=%0d must be a multiple of W=%0d and fit the 11-bit counter",
           INIT_ROUNDS, W);
  end

  localparam logic [10:0] W_STEP = 11'(W);
  localparam logic [10:0] ROUNDS = 11'(INIT_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [287:0]   s_q, s_d;
  logic [10:0]    cnt_q, cnt_d;

  logic [287:0]   walk;
  logic [288:0]   step_res;
  logic [287:0]   adv_state;
  logic [W-1:0]   adv_ks;

  // Initial state for a (key, iv) pair: key into s1..s80, iv into s94..s173,
  // s286..s288 set, everything else cleared.
  function automatic logic [287:0] load_state(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s          = 288'd0;
    s[79:0]    = k;
    s[172:93]  = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  // One Trivium update; returns {z, next_state}. z is taken before the
  // nonlinear feedback terms are folded in.
  function automatic logic [288:0] trivium_step(input logic [287:0] s);
    logic         t1, t2, t3, z;
    logic [287:0] n;
    t1 = s[65]  ^ s[92];
    t2 = s[161] ^ s[176];
    t3 = s[242] ^ s[287];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[90]  & s[91])  ^ s[170];
    t2 = t2 ^ (s[174] & s[175]) ^ s[263];
    t3 = t3 ^ (s[285] & s[286]) ^ s[68];
    n  = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    return {z, n};
  endfunction

  // Unroll W steps from the registered state; bit k of the word is z of step k.
  always_comb begin
    walk     = s_q;
    step_res = 289'd0;
    adv_ks   = '0;
    for (int k = 0; k < W; k++) begin
      step_res  = trivium_step(walk);
      adv_ks[k] = step_res[288];
      walk      = step_res[287:0];
    end
    adv_state = walk;
  end

  // Next-state logic: load beats everything, INIT free-runs, RUN advances on a handshake.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    if (load) begin
      s_d     = load_state(key, iv);
      cnt_d   = 11'd0;
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_INIT: begin
          s_d   = adv_state;
          cnt_d = cnt_q + W_STEP;
          if (cnt_q + W_STEP == ROUNDS) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_INIT;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            s_d = adv_state;
          end else begin
            s_d = s_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          s_d     = 288'd0;
          cnt_d   = 11'd0;
        end
      endcase
    end
  end

  // State, cipher state and warm-up counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 288'd0;
      cnt_q   <= 11'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_INIT);
  assign out_valid = (state_q == ST_RUN);
  assign ks        = out_valid ? adv_ks : '0;

endmodule
